// File: rtl/pipelined_carry_adder_pkg.sv
// Shared configuration helpers for the pipelined carry adder:
// slice width derivation and the WIDTH/STAGES legality check.
package pipelined_carry_adder_pkg;

  function automatic bit cfg_ok(input int w, input int s);
    return (s >= 1) ? ((s <= w) && (w % s == 0)) : 1'b0;
  endfunction

  function automatic int slice_w(input int w, input int s);
    return (s >= 1) ? w / s : 1;
  endfunction

endpackage

// File: rtl/pipelined_carry_adder_slice_adder.sv
// Combinational SW-bit ripple chain of full-adder cells,
// one instance per pipeline stage.
module slice_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  logic [SW:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i])
                     | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[SW];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit adder, one carry slice per stage, valid/ready.
// Optional signed overflow output: PIPELINED_CARRY_ADDER_OVF_EN.
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_carry_adder: illegal WIDTH/STAGES");
  end

  logic w_adv;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:LO] w_a;
    logic [WIDTH-1:LO] w_b;
    logic              w_ci;
    logic              w_vi;
    logic [SW-1:0]     w_s;
    logic              w_co;
    logic [HI-1:0]     w_nxt;

    logic              r_v;
    logic [HI-1:0]     r_s;
    logic              r_c;

    if (k == 0) begin : g_src
      assign w_a   = a;
      assign w_b   = b;
      assign w_ci  = cin;
      assign w_vi  = in_valid;
      assign w_nxt = w_s;
    end else begin : g_src
      assign w_a   = g_st[k-1].g_fwd.r_a;
      assign w_b   = g_st[k-1].g_fwd.r_b;
      assign w_ci  = g_st[k-1].r_c;
      assign w_vi  = g_st[k-1].r_v;
      assign w_nxt = {w_s, g_st[k-1].r_s};
    end

    slice_adder #(
      .SW(SW)
    ) u_add (
      .a   (w_a[HI-1:LO]),
      .b   (w_b[HI-1:LO]),
      .cin (w_ci),
      .sum (w_s),
      .cout(w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vi;
      end
    end

    // Bubbles leave the data registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv && w_vi) begin
        r_s <= w_nxt;
        r_c <= w_co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vi) begin
          r_a <= w_a[WIDTH-1:HI];
          r_b <= w_b[WIDTH-1:HI];
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  logic w_cmsb;
  logic r_ovf;

  // Carry into the MSB recovered from its sum bit.
  assign w_cmsb = g_st[STAGES-1].w_a[WIDTH-1]
                ^ g_st[STAGES-1].w_b[WIDTH-1]
                ^ g_st[STAGES-1].w_s[SW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv && g_st[STAGES-1].w_vi) begin
      r_ovf <= w_cmsb ^ g_st[STAGES-1].w_co;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (16 bits, 4 stages)
// against an arithmetic reference queue.
module tb_pipelined_carry_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  bit last_in_x;

  logic [17:0] q[$];

  pipelined_carry_adder #(
    .WIDTH (16),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] ref_add(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c
  );
    int u;
    int s;
    logic [16:0] t;
    logic        v;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    t = 17'(u);
    v = (s > 32767) || (s < -32768);
    return {v, t};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: handshake bookkeeping, then advance to next negedge.
  task automatic cyc();
    bit in_x;
    bit out_x;
    logic [17:0] e;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    if (out_x) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL spurious observed=%h expected=none",
               {cout, sum});
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", {15'd0, cout, sum}, {15'd0, e[16:0]});
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e[17]});
`endif
      end
      n_out++;
    end
    if (in_x) q.push_back(ref_add(a, b, cin));
    last_in_x = in_x;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single(
    input string       tag,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic [16:0] exp,
    input logic        exp_ovf
  );
    int n;
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk(tag, {15'd0, cout, sum}, {15'd0, exp});
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf) begin end
`endif
    cyc();
  endtask

  initial begin
    logic [15:0] held;
    int i;
    int issued;
    int base;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_sum", {16'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("idle_out_valid", {31'd0, out_valid}, 0);
    end

    single("add1234", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    single("add00ff", 16'h00ff, 16'h0001, 1'b0, 17'h00100, 1'b0);
    single("wrap", 16'hffff, 16'h0000, 1'b1, 17'h10000, 1'b0);
    single("fullc", 16'hffff, 16'hffff, 1'b1, 17'h1ffff, 1'b0);
    single("wrap01", 16'hffff, 16'h0001, 1'b0, 17'h10000, 1'b0);
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    single("ovf_pos", 16'h7fff, 16'h0001, 1'b0, 17'h08000, 1'b1);
    single("ovf_neg", 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1);
`endif

    // back-to-back stream with out_ready low in cycles 6..9
    base = n_out;
    issued = 0;
    i = 0;
    held = '0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    while ((issued < 8 || q.size() != 0) && i < 60) begin
      out_ready = !(i >= 6 && i <= 9);
      in_valid = (issued < 8);
      #1;
      if (i == 6) held = sum;
      if (i >= 6 && i <= 9) begin
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        chk("stall_out_valid", {31'd0, out_valid}, 1);
        chk("stall_sum", {16'd0, sum}, {16'd0, held});
      end
      cyc();
      if (last_in_x) begin
        issued++;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
      end
      i++;
    end
    in_valid = 1'b0;
    chk("stream_count", n_out - base, 8);
    chk("stream_drained", q.size(), 0);

    // reset with three results in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    i = 0;
    while (!out_valid && i < 20) begin
      cyc();
      i++;
    end
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_sum", {16'd0, sum}, 0);
    chk("mid_rst_ready", {31'd0, in_ready}, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) cyc();
    chk("post_rst_count", n_out - base, 2);

    // random traffic on both sides
    base = n_out;
    issued = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      cyc();
      if (last_in_x) begin
        issued++;
        case ($urandom_range(0, 3))
          0: a = 16'hffff;
          1: a = 16'h8000;
          default: a = 16'($urandom);
        endcase
        b = 16'($urandom);
        cin = 1'($urandom);
        in_valid = ($urandom_range(0, 9) < 7);
      end else if (!in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    i = 0;
    while (q.size() != 0 && i < 30) begin
      cyc();
      i++;
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_count", n_out - base, issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the single-bit full adder: adds two WIDTH-bit operands plus carry-in.
- Splits the carry chain into STAGES equal slices, one register stage per slice.
- Valid/ready handshake on input and output; sustains one addition per clock when unstalled.
- Used as the datapath adder in wider arithmetic blocks where a full-width ripple chain would not meet timing.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH; slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  adder accepts an operand set this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits = 0, out_valid=0, sum=0, cout=0. in_ready follows its equation, so it reads 1 during reset.
- Stall rule:
  - advance = !out_valid || out_ready. The whole pipe moves together, with no bubble squeezing.
  - in_ready = advance (combinational). An input transfer occurs when in_valid && in_ready.
- Stage k (0..STAGES-1) on advance:
  - computes slice k = a[k*SW +: SW] + b[k*SW +: SW] + carry_k with a ripple chain of full-adder cells.
  - carry_0 = cin; carry_k = registered carry out of stage k-1.
  - Registers the slice result, its carry out, and the not-yet-added upper operand slices.
  - Lower sum slices already computed are carried forward unchanged.
- Latency: result of a transfer in cycle t has out_valid=1 in cycle t+STAGES, provided no stall occurs.
- Throughput: 1 result/cycle while out_ready=1.
- When advance=0: every register, including valid bits, holds its value. sum/cout are stable while out_valid=1 && out_ready=0.
- When advance=1 and in_valid=0: a bubble (valid=0) enters stage 0. Data registers may load don't-care, but sum/cout update only when the stage valid bit is 1.
- Wrap-around: a=FFFF, b=0001, cin=0 gives sum=0000, cout=1. Arithmetic is modulo 2^WIDTH, with the carry exposed on cout.
- STAGES=1: single registered WIDTH-bit ripple add, latency 1.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight results are discarded, and out_valid drops immediately and asynchronously.

Optional Feature:
- Macro: PIPELINED_CARRY_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow of a + b + cin, i.e. carry into MSB XOR carry out of MSB.
  - Computed in the last stage and aligned with sum; reset value 0.
  - Held on stall like sum.
- Undefined: port ovf does not exist; no extra logic.

Decomposition:
- Shared package/header: slice-width constant SW derived from WIDTH/STAGES, and the legality check (WIDTH % STAGES == 0, STAGES ≥ 1), which fails elaboration if violated.
- Sub-module: slice_adder (combinational SW-bit ripple chain of full-adder cells; inputs a, b, cin; outputs sum, cout). Instantiated once per stage via generate.
- Stage registers stay in pipelined_carry_adder.

Test Plan:
- Reset then idle: rst_n=0 → out_valid=0, sum=0, cout=0, in_ready=1. Release reset with in_valid=0 for 10 cycles → out_valid stays 0.
- Single add (WIDTH=16, STAGES=4):
  - a=1234, b=4321, cin=0 → out_valid=1 exactly 4 cycles later with sum=5555, cout=0.
  - a=00FF, b=0001, cin=0 → sum=0100; checks carry crossing slice boundaries.
- Wrap and full carry chain:
  - a=FFFF, b=0000, cin=1 → sum=0000, cout=1.
  - a=FFFF, b=FFFF, cin=1 → sum=FFFF, cout=1.
- Back-pressure: stream 8 random operand sets back-to-back and hold out_ready=0 for cycles 6–9.
  - in_ready=0 during the stall; sum held stable.
  - All 8 results delivered in order, none lost or duplicated; compared against a reference model.
- Reset mid-stream: assert rst_n=0 with 3 results in flight → out_valid=0 immediately. After release, only newly issued operands produce results.
- With PIPELINED_CARRY_ADDER_OVF_EN defined:
  - a=7FFF, b=0001, cin=0 → sum=8000, ovf=1, cout=0.
  - a=8000, b=8000 → sum=0000, ovf=1, cout=1.
